// File: rtl/prbs_checker.sv
// Self-synchronising checker for the parallel LFSR word stream; outputs registered, one cycle after the accepted word.
// No backpressure: a word may arrive every cycle and in_valid=0 cycles leave all state untouched.
module prbs_checker #(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] TAPS       = 'hB8,
   parameter int unsigned      LOCK_COUNT = 4,
   parameter int unsigned      LOSS_COUNT = 3,
   parameter int unsigned      CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic             zero_word
);

   typedef enum logic [1:0] {SEED, SEARCH, LOCKED} state_t;

   localparam logic [7:0] LOCK_LIM = 8'(LOCK_COUNT);
   localparam logic [7:0] LOSS_LIM = 8'(LOSS_COUNT);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   ref_word, ref_word_nxt;
   logic [7:0]         match_cnt, match_cnt_nxt;
   logic [7:0]         miss_cnt, miss_cnt_nxt;
   logic               err_pulse_nxt;
   logic [CNT_W-1:0]   err_count_nxt;
   logic               zero_word_nxt;
   logic [WIDTH-1:0]   pred;
   logic               is_zero;
   logic               is_match;

   // The all-zero word is its own successor, so it must never count as a match.
   assign pred     = {ref_word[WIDTH-2:0], ^(ref_word & TAPS)};
   assign is_zero  = (in_data == '0);
   assign is_match = (in_data == pred) && !is_zero;

   always_comb begin
      state_nxt     = state;
      ref_word_nxt  = ref_word;
      match_cnt_nxt = match_cnt;
      miss_cnt_nxt  = miss_cnt;
      err_pulse_nxt = 1'b0;
      err_count_nxt = err_count;
      zero_word_nxt = zero_word;

      if (in_valid) begin
         case (state)
            SEED: begin
               ref_word_nxt  = in_data;
               match_cnt_nxt = '0;
               state_nxt     = SEARCH;
            end
            SEARCH: begin
               ref_word_nxt = in_data;
               if (is_match) begin
                  match_cnt_nxt = match_cnt + 8'd1;
                  if (match_cnt + 8'd1 == LOCK_LIM) begin
                     state_nxt    = LOCKED;
                     miss_cnt_nxt = '0;
                  end
               end else begin
                  match_cnt_nxt = '0;
               end
            end
            LOCKED: begin
               if (is_match) begin
                  ref_word_nxt = in_data;
                  miss_cnt_nxt = '0;
               end else begin
                  // Coast on the prediction so a single corrupted word costs one error only.
                  err_pulse_nxt = 1'b1;
                  ref_word_nxt  = pred;
                  miss_cnt_nxt  = miss_cnt + 8'd1;
                  if (err_count != {CNT_W{1'b1}})
                     err_count_nxt = err_count + 1'b1;
                  if (miss_cnt + 8'd1 == LOSS_LIM) begin
                     state_nxt     = SEARCH;
                     ref_word_nxt  = in_data;
                     match_cnt_nxt = '0;
                  end
               end
            end
            default: state_nxt = SEED;
         endcase
         if (is_zero)
            zero_word_nxt = 1'b1;
      end

      if (clear) begin
         err_count_nxt = '0;
         zero_word_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= SEED;
         ref_word  <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
         zero_word <= 1'b0;
      end else begin
         state     <= state_nxt;
         ref_word  <= ref_word_nxt;
         match_cnt <= match_cnt_nxt;
         miss_cnt  <= miss_cnt_nxt;
         locked    <= (state_nxt == LOCKED);
         err_pulse <= err_pulse_nxt;
         err_count <= err_count_nxt;
         zero_word <= zero_word_nxt;
      end
   end

endmodule
